// File: rtl/md_unit_sched.sv
// Multiply/divide scheduler for the MIPS pipeline: owns HI/LO, runs fixed-latency
// mult/div operations and raises md_stall while an HI/LO user waits in D.
module md_unit_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_md,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        md_stall
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] div_q;
    logic [31:0] div_r;

    // Issue handshake: an op in E is accepted in the cycle start=1, which only
    // happens while busy=0; the stall keeps a second op from reaching E meanwhile.
    assign busy     = (state == RUN);
    assign start    = (E_md_op >= OP_MULT) && (E_md_op <= OP_DIVU) && !busy;
    assign md_stall = D_md & (start | busy);
    assign HI       = hi_q;
    assign LO       = lo_q;

    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    always_comb begin
        prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u     = {32'b0, a_q} * {32'b0, b_q};
        signed_div = (op_q == OP_DIV);
        a_neg      = signed_div & a_q[31];
        b_neg      = signed_div & b_q[31];
        a_mag      = a_neg ? -a_q : a_q;
        b_mag      = b_neg ? -b_q : b_q;
        q_mag      = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
        r_mag      = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
        div_q      = (a_neg ^ b_neg) ? -q_mag : q_mag;
        div_r      = a_neg ? -r_mag : r_mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= E_md_op;
                        a_q   <= E_A;
                        b_q   <= E_B;
                        cnt   <= (E_md_op >= OP_DIV) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        state <= RUN;
                    end else if (E_md_op == OP_MTHI) begin
                        hi_q <= E_A;
                    end else if (E_md_op == OP_MTLO) begin
                        lo_q <= E_A;
                    end
                end
                RUN: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        case (op_q)
                            OP_MULT:  {hi_q, lo_q} <= prod_s;
                            OP_MULTU: {hi_q, lo_q} <= prod_u;
                            OP_DIV, OP_DIVU: begin
                                // Divide by zero leaves HI/LO untouched.
                                if (b_q != 32'd0) begin
                                    hi_q <= div_r;
                                    lo_q <= div_q;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/md_unit_sched.md
# md_unit_sched

Multiply/divide scheduler for the five-stage MIPS pipeline. It accepts mult/multu/div/divu and mthi/mtlo from stage E, runs a fixed-latency iterative multiply or divide, and owns the HI/LO registers. It raises `md_stall` so the hazard controller can freeze F/D and bubble E while any HI/LO-using instruction sits in D and the unit is starting or busy.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high. Clears all state immediately.
- `E_md_op`, in, 3: stage-E operation. 0 = none, 1 = mult, 2 = multu, 3 = div, 4 = divu, 5 = mthi, 6 = mtlo. 7 is treated as none.
- `E_A`, in, 32: rs operand, already forwarded.
- `E_B`, in, 32: rt operand, already forwarded.
- `D_md`, in, 1: stage-D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `start`, out, 1: combinational. High when `E_md_op` is 1–4 and `busy` = 0.
- `busy`, out, 1: registered. High while an operation is in progress.
- `HI`, out, 32: registered HI.
- `LO`, out, 32: registered LO.
- `md_stall`, out, 1: combinational. Equals `D_md & (start | busy)`.

## Operation
- States: IDLE (`busy` = 0) and RUN (`busy` = 1). A 4-bit down-counter `cnt` is held alongside.
- IDLE, `start` = 1:
  - Latch the op type, `E_A` and `E_B` into internal operand registers.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN: `cnt` decrements each cycle. On the edge where `cnt` = 1:
  - Write the result to HI/LO.
  - Clear `busy`.
  - Return to IDLE.
- Result definitions:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - divu: unsigned quotient in LO, remainder in HI.
  - Divide by zero (`E_B` = 0 at start): the unit still busies for DIV_CYCLES, and HI/LO are left unchanged at completion.
- The result may be computed combinationally from the latched operands or iteratively. Either way, it is visible only at completion.
- mthi/mtlo in IDLE: HI ← `E_A` (or LO ← `E_A`) on that edge. There is no busy period.
- Ops arriving while `busy` = 1 are ignored (`start` is gated). The stall protocol guarantees this never happens.
- mfhi/mflo read the `HI`/`LO` ports directly. Because of `md_stall`, they never observe a stale value.
- Reset:
  - `busy` = 0, `cnt` = 0, HI = 0, LO = 0, operand registers = 0.
  - `start` and `md_stall` then follow their equations.
  - Reset mid-RUN aborts the operation with no HI/LO write.

## Timing
- Issue cycle T (`start` = 1): `busy` rises at edge T+1.
- `busy` is high for exactly N cycles, T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES).
- HI/LO are updated at edge T+N+1, and `busy` falls at the same edge.
- `md_stall` is high in cycle T (via `start`) and in cycles T+1 … T+N if `D_md` = 1.
- An mfhi in D therefore issues to E in cycle T+N+1 at the earliest and sees the new value.
- A back-to-back mult in E at cycle T+N+1 is accepted (`busy` = 0 by then).
- mthi at edge T changes HI at T+1.

## Test plan
- Signed multiply: mult, `E_A` = 0xFFFFFFFD (−3), `E_B` = 5.
  - `busy` high for 5 cycles.
  - HI = 0xFFFFFFFF, LO = 0xFFFFFFF1 after T+6.
  - HI/LO unchanged before that.
- Signed divide, then unsigned divide:
  - div −7/2: HI = 0xFFFFFFFF, LO = 0xFFFFFFFD after 10 busy cycles.
  - divu 7/2: HI = 1, LO = 3.
  - div 0x80000000/−1: LO = 0x80000000, HI = 0.
- Stall window: multu 0xFFFFFFFF × 2 with `D_md` = 1 held.
  - `md_stall` = 1 for cycles T … T+5, then 0.
  - HI = 1, LO = 0xFFFFFFFE.
  - With `D_md` = 0, `md_stall` stays 0 throughout.
- Divide by zero: preload LO = 0x1234 via mtlo, then div 9/0.
  - `busy` high for 10 cycles.
  - HI/LO remain at their prior values.
- Reset mid-operation: start div 100/3, assert `reset` asynchronously at cycle T+4.
  - `busy`, HI and LO go to 0 immediately, without waiting for a clock edge.
  - No write occurs after `reset` is released.
- Ignore while busy and mthi: present mult in E while `busy` = 1.
  - `start` = 0, and the result matches the first operation only.
  - Then mthi 0xDEADBEEF in IDLE gives HI = 0xDEADBEEF next cycle, with `busy` staying 0.
